// File: rtl/tile_palette_pkg.sv
// Shared types and constants for the tile palette arbiter and its fade scaler.
package tile_palette_pkg;

   localparam int LEVEL_MAX = 16;
   localparam int LEVEL_W   = 5;

   // fade_cmd encodings; 2'b11 behaves exactly like 2'b00
   localparam logic [1:0] CMD_NONE     = 2'b00;
   localparam logic [1:0] CMD_FADE_IN  = 2'b01;
   localparam logic [1:0] CMD_FADE_OUT = 2'b10;
   localparam logic [1:0] CMD_NONE_ALT = 2'b11;

   // requester identity as carried through the pipeline and in last_grant
   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_IN  = 2'd1,
      FADE_OUT = 2'd2
   } fade_state_t;

endpackage

// File: rtl/palette_channel_scale.sv
// Scales one 4-bit colour channel by a 0..16 fade level: (c * level) >> 4.
module palette_channel_scale
   import tile_palette_pkg::*;
(
   input  logic [3:0]         color,
   input  logic [LEVEL_W-1:0] level,
   output logic [3:0]         scaled
);

   // 15 * 16 = 240 is the largest product, so bits [7:4] hold the result
   logic [8:0] product;

   assign product = 9'(color) * 9'(level);
   assign scaled  = 4'(product >> 4);

endmodule

// File: rtl/tile_palette_arbiter.sv
// Round-robin arbiter for two palette requesters sharing one external palette,
// followed by a two-stage pipeline that applies a frame-timed brightness fade.
module tile_palette_arbiter
   import tile_palette_pkg::*;
#(
   parameter int FADE_FRAMES = 4
)(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               req_a_valid,
   input  logic [3:0]         req_a_index,
   output logic               req_a_ready,
   input  logic               req_b_valid,
   input  logic [3:0]         req_b_index,
   output logic               req_b_ready,
   output logic [3:0]         pal_index,
   input  logic [3:0]         pal_red,
   input  logic [3:0]         pal_green,
   input  logic [3:0]         pal_blue,
   input  logic               frame_start,
   input  logic [1:0]         fade_cmd,
   output logic               out_valid,
   output logic               out_src,
   output logic [3:0]         out_red,
   output logic [3:0]         out_green,
   output logic [3:0]         out_blue,
   output logic               fade_busy,
   output logic [LEVEL_W-1:0] fade_level
);

   localparam logic [7:0]         FRAMES_LAST = 8'(FADE_FRAMES - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(LEVEL_MAX);

   logic        grant_a;
   logic        grant_b;
   logic        last_grant;
   logic        s1_valid;
   logic        s1_src;
   logic [3:0]  s1_red;
   logic [3:0]  s1_green;
   logic [3:0]  s1_blue;
   logic [3:0]  scaled_red;
   logic [3:0]  scaled_green;
   logic [3:0]  scaled_blue;
   logic [7:0]  frame_cnt;
   logic        frame_hit;
   fade_state_t state;
   fade_state_t state_next;

   // Grant decision: lone requester wins, a tie goes to whoever did not win last
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (req_a_valid && req_b_valid) begin
         if (last_grant == SRC_B) grant_a = 1'b1;
         else                     grant_b = 1'b1;
      end else begin
         grant_a = req_a_valid;
         grant_b = req_b_valid;
      end
   end

   assign req_a_ready = grant_a;
   assign req_b_ready = grant_b;
   assign pal_index   = grant_a ? req_a_index : (grant_b ? req_b_index : 4'd0);

   // Stage 1: capture the palette response and its source at the grant edge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_grant <= SRC_B;
         s1_valid   <= 1'b0;
         s1_src     <= SRC_A;
         s1_red     <= 4'd0;
         s1_green   <= 4'd0;
         s1_blue    <= 4'd0;
      end else begin
         s1_valid <= grant_a | grant_b;
         if (grant_a | grant_b) begin
            last_grant <= grant_b;
            s1_src     <= grant_b;
            s1_red     <= pal_red;
            s1_green   <= pal_green;
            s1_blue    <= pal_blue;
         end
      end
   end

   palette_channel_scale u_scale_red   (.color(s1_red),   .level(fade_level), .scaled(scaled_red));
   palette_channel_scale u_scale_green (.color(s1_green), .level(fade_level), .scaled(scaled_green));
   palette_channel_scale u_scale_blue  (.color(s1_blue),  .level(fade_level), .scaled(scaled_blue));

   // Stage 2: register the faded colour; data holds between valid outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_valid <= 1'b0;
         out_src   <= SRC_A;
         out_red   <= 4'd0;
         out_green <= 4'd0;
         out_blue  <= 4'd0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_src   <= s1_src;
            out_red   <= scaled_red;
            out_green <= scaled_green;
            out_blue  <= scaled_blue;
         end
      end
   end

   // A fade step happens on the frame_start that completes FADE_FRAMES frames
   assign frame_hit = frame_start && (frame_cnt == FRAMES_LAST);

   // Fade FSM state register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Fade FSM next state: commands only heard in IDLE; leave a fade on its end step
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fade_cmd == CMD_FADE_IN)       state_next = FADE_IN;
            else if (fade_cmd == CMD_FADE_OUT) state_next = FADE_OUT;
         end
         FADE_IN: begin
            if (frame_hit && (fade_level >= LEVEL_TOP - 1'b1)) state_next = IDLE;
         end
         FADE_OUT: begin
            if (frame_hit && (fade_level <= LEVEL_W'(1))) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Fade FSM outputs
   always_comb begin
      fade_busy = (state != IDLE);
   end

   // Frame counter and saturating fade level; the counter idles at zero so a
   // new fade always starts counting from the first frame after entry
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_cnt  <= 8'd0;
         fade_level <= LEVEL_TOP;
      end else if (state == IDLE) begin
         frame_cnt <= 8'd0;
      end else if (frame_start) begin
         frame_cnt <= frame_hit ? 8'd0 : frame_cnt + 8'd1;
         if (frame_hit) begin
            if (state == FADE_IN && fade_level != LEVEL_TOP)
               fade_level <= fade_level + 1'b1;
            else if (state == FADE_OUT && fade_level != '0)
               fade_level <= fade_level - 1'b1;
         end
      end
   end

endmodule

// File: doc/tile_palette_arbiter.md
TILE_PALETTE_ARBITER -- requirements
Module: tile_palette_arbiter

Interface
REQ-001 SHALL have parameter FADE_FRAMES, default 4: frame_start pulses per fade step (legal range 1..255).
REQ-002 SHALL use one clock and an asynchronous, active-low reset; ports Clk and Reset_n are listed first.
REQ-003 Clk  in  1  system/pixel clock; all state changes on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_a_valid  in  1  requester A (background tile) has a lookup pending.
REQ-006 req_a_index  in  4  requester A palette index.
REQ-007 req_a_ready  out  1  A granted this cycle (combinational).
REQ-008 req_b_valid / req_b_index / req_b_ready  in/in/out  1/4/1  same meaning for requester B (sprite).
REQ-009 pal_index  out  4  index driven to the shared 16-entry palette (combinational from grant).
REQ-010 pal_red / pal_green / pal_blue  in  4 each  palette response, valid in the same cycle as pal_index.
REQ-011 frame_start  in  1  one-cycle pulse per frame (vsync).
REQ-012 fade_cmd  in  2  00 none, 01 fade-in, 10 fade-out, 11 none.
REQ-013 out_valid  out  1  scaled colour valid; out_src  out  1  0=A, 1=B.
REQ-014 out_red / out_green / out_blue  out  4 each  faded colour.
REQ-015 fade_busy  out  1  high in FADE_IN or FADE_OUT; fade_level  out  5  current level 0..16.

Function
REQ-016 Arbiter: one grant per cycle; single valid requester is granted; both valid -> grant opposite of last_grant (round-robin); no valid -> no grant, pal_index = 0.
REQ-017 last_grant updates only on a grant; reset value B, so A wins the first tie.
REQ-018 pal_index = granted requester's index; ready is asserted only to the granted requester.
REQ-019 Stage 1 registers pal_red/green/blue, source and valid at the grant edge; stage 2 registers scaled colour; out_valid asserted exactly 2 cycles after grant; no output back-pressure.
REQ-020 Scaling per channel: out = (c * fade_level) >> 4, 9-bit product, bits [7:4] taken; level 16 -> c unchanged, level 0 -> 0.
REQ-021 Scaling uses fade_level as registered in the cycle stage 2 captures.
REQ-022 FSM states IDLE, FADE_IN, FADE_OUT; IDLE samples fade_cmd each cycle: 01 -> FADE_IN, 10 -> FADE_OUT, else stay; fade_cmd ignored while busy.
REQ-023 Entering a fade clears the frame counter; frame_start in the entry cycle is not counted.
REQ-024 Each counted frame_start increments the counter; on reaching FADE_FRAMES, counter clears and fade_level steps +1 (FADE_IN) or -1 (FADE_OUT).
REQ-025 FADE_IN reaching 16 or FADE_OUT reaching 0 returns to IDLE the same edge; a command already at its end level (fade-in at 16, fade-out at 0) returns to IDLE on the next frame step without changing level.
REQ-026 fade_level never wraps; saturates at 0 and 16.

Reset
REQ-027 Reset asserted: FSM IDLE, fade_level 16, frame counter 0, last_grant B, stage valids 0, out_red/green/blue 0, out_src 0, fade_busy 0.
REQ-028 Reset mid-fade or mid-pipeline discards in-flight lookups; no out_valid for them after release.

Structure
REQ-029 Package tile_palette_pkg holds fade_state_t enum, fade_cmd code constants, LEVEL_MAX = 16, LEVEL_W = 5.
REQ-030 One sub-module palette_channel_scale (4-bit colour x 5-bit level -> 4-bit), instantiated three times; the palette itself remains external.

Verification
REQ-031 Both requesters valid 4 cycles, A idx 1, B idx 4 -> grants A,B,A,B; out_src 0,1,0,1 with out_valid 2 cycles after each grant.
REQ-032 Only B valid 3 cycles, palette idx 4 returns {E,A,9}, level 16 -> out {E,A,9}, out_src 1, no A ready.
REQ-033 FADE_FRAMES=2, fade_cmd=10 from level 16, 32 frame_start pulses -> level 15 after 2nd pulse, 0 after 32nd, fade_busy falls same edge.
REQ-034 Level 8, colour {D,9,7} -> out {6,4,3}; level 0 -> {0,0,0}.
REQ-035 fade_cmd=01 issued during FADE_OUT -> ignored; level continues decreasing.
REQ-036 Reset_n pulled low mid-fade with 2 lookups in flight -> level 16, IDLE, no out_valid after release until a new grant.
